// File: rtl/reg_dump_streamer_if.sv
// Stream interface for reg_dump_streamer: one register word per transfer
// with a valid/ready handshake. The master presents index and data; the
// slave accepts the word with out_ready.
interface reg_dump_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_index;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: reads the register file's packed debug bus and streams
// the architectural registers, one per transfer, in ascending index order.
// With SKIP_R0 set, the hard-wired r0 is left out of the dump.
//
// Optional feature: define REG_DUMP_SNAPSHOT_EN to capture the whole debug
// bus into a shadow register at the start edge, so the dump is an atomic
// image of that cycle. Without it, each word is read from the live bus at
// the edge where its index is loaded.
module reg_dump_streamer #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SKIP_R0    = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] debug_registers,
  reg_dump_streamer_if.master            stream,
  output logic                           busy,
  output logic                           done
);

  localparam int         BUS_W     = NUM_REGS * DATA_WIDTH;
  localparam logic [4:0] FIRST_IDX = (SKIP_R0 != 0) ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            index_q, index_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;

  logic [4:0]            nextIdx;
  logic [BUS_W-1:0]      srcBus;
  logic [DATA_WIDTH-1:0] firstSlice;
  logic [DATA_WIDTH-1:0] nextSlice;

`ifdef REG_DUMP_SNAPSHOT_EN
  logic [BUS_W-1:0]      shadow_q, shadow_d;

  // Later words come from the image frozen at the start edge.
  assign srcBus = shadow_q;
`else
  // Later words come straight from the live register file.
  assign srcBus = debug_registers;
`endif

  // The first word is always taken from the live bus: at the start edge the
  // shadow (when present) is being loaded with exactly that same value.
  assign nextIdx    = index_q + 5'd1;
  assign firstSlice = debug_registers[int'(FIRST_IDX)*DATA_WIDTH +: DATA_WIDTH];
  assign nextSlice  = srcBus[int'(nextIdx)*DATA_WIDTH +: DATA_WIDTH];

  // Next-state logic: start in IDLE loads the first word; each handshake in
  // SEND either advances to the next index or, on the last index, finishes.
  // The terminal check comes before the increment so the index never wraps.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef REG_DUMP_SNAPSHOT_EN
    shadow_d = shadow_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          index_d = FIRST_IDX;
          data_d  = firstSlice;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef REG_DUMP_SNAPSHOT_EN
          shadow_d = debug_registers;
`endif
        end
      end
      SEND: begin
        if (valid_q && stream.out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = nextIdx;
            data_d  = nextSlice;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any dump in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef REG_DUMP_SNAPSHOT_EN
  // Shadow image of the debug bus, loaded only at the start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign stream.out_valid = valid_q;
  assign stream.out_index = index_q;
  assign stream.out_data  = data_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
